// File: rtl/lrhls_mul_pkg.sv
// rtl/lrhls_mul_pkg.sv - shared widths, operand/response types and multiply helper
//
// Purpose: common definitions for the shared-multiplier arbiter and its response FIFO.
//   MUL_IN_W  : operand width of the shared 17x17 unsigned multiplier
//   MUL_OUT_W : full product width (no truncation)
//   MUL_ID_W  : tag width wide enough for the largest requester count (16)
//   mul_op_t  : operand pair plus requester tag, as held in the first pipeline stage
//   mul_rsp_t : product plus requester tag, as held in later stages and the FIFO
package lrhls_mul_pkg;

  localparam int MUL_IN_W  = 17;
  localparam int MUL_OUT_W = 34;
  localparam int MUL_ID_W  = 4;

  typedef struct packed {
    logic [MUL_IN_W-1:0] a;
    logic [MUL_IN_W-1:0] b;
    logic [MUL_ID_W-1:0] id;
  } mul_op_t;

  typedef struct packed {
    logic [MUL_OUT_W-1:0] p;
    logic [MUL_ID_W-1:0]  id;
  } mul_rsp_t;

  // Full-width unsigned product; operands are widened first so nothing is lost.
  function automatic logic [MUL_OUT_W-1:0] mul_full(input logic [MUL_IN_W-1:0] a,
                                                    input logic [MUL_IN_W-1:0] b);
    return MUL_OUT_W'(a) * MUL_OUT_W'(b);
  endfunction

endpackage

// File: rtl/lrhls_mul_share_arb_if.sv
// rtl/lrhls_mul_share_arb_if.sv - request/response bundle of the shared-multiplier arbiter
//
// Purpose: groups the requester handshake, the product stream and the credit count.
//   req_valid/req_ready : per-requester handshake, requester i on bit i
//   req_a/req_b         : packed 17-bit operands, requester i at [17i+16:17i]
//   rsp_valid/rsp_ready : product stream handshake
//   rsp_data/rsp_id     : 34-bit product and originating requester index
//   credits_used        : in-flight products plus FIFO occupancy
// Modports: master = requester/consumer side, slave = arbiter side.
interface lrhls_mul_share_arb_if
  import lrhls_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*MUL_IN_W-1:0] req_a;
  logic [NUM_REQ*MUL_IN_W-1:0] req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [MUL_OUT_W-1:0]        rsp_data;
  logic [ID_W-1:0]             rsp_id;
  logic [CNT_W-1:0]            credits_used;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, credits_used
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, credits_used
  );

endinterface

// File: rtl/lrhls_mul_rsp_fifo.sv
// rtl/lrhls_mul_rsp_fifo.sv - first-word-fall-through FIFO for tagged products
//
// Purpose: holds finished products until the downstream consumer takes them.
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_en_i      : push wr_data_i (caller guarantees the FIFO is not full)
//   rd_en_i      : pop the head when rd_valid_o is 1
//   rd_valid_o   : FIFO not empty
//   rd_data_o    : head entry; when empty, the last popped entry (zero after reset)
//   count_o      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
module lrhls_mul_rsp_fifo
  import lrhls_mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  mul_rsp_t                 wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output mul_rsp_t                 rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mul_rsp_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  mul_rsp_t         hold_q;
  logic             push;
  logic             pop;

  assign push = wr_en_i;
  assign pop  = rd_en_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit gating upstream makes a write into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(wr_en_i && (count_q == CNT_W'(DEPTH))));
    end
  end

  // Holding the last popped word keeps rsp_data/rsp_id stable while empty.
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : hold_q;
  assign count_o    = count_q;

endmodule

// File: rtl/lrhls_mul_share_arb.sv
// rtl/lrhls_mul_share_arb.sv - round-robin arbiter time-sharing one 17x17 multiplier
//
// Purpose: grants one requester per cycle (round-robin from rr_ptr), pushes the
// operand pair through a MUL_STAGES-deep multiply pipeline and queues the tagged
// product in a response FIFO. A credit counter covers in-flight plus queued
// products so back-pressure never causes loss.
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   bus (slave)    : requester handshake/operands, product stream, credits_used
module lrhls_mul_share_arb
  import lrhls_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MUL_STAGES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  lrhls_mul_share_arb_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic             accept;
  logic             pop;
  mul_op_t          op_d;
  mul_op_t          s1_op_q;
  logic             s1_valid_q;
  logic             fifo_wr;
  mul_rsp_t         fifo_wr_data;
  mul_rsp_t         fifo_head;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_count;

  // First valid requester at or after rr_ptr, searching cyclically upward.
  always_comb begin : arb_search
    int              pos;
    logic [ID_W-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos  = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand = ID_W'(pos);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The credit check uses only the registered count, so a pop frees a slot
  // for the following cycle at the earliest and req_ready ignores rsp_ready.
  assign accept = win_found && (credits_q < CNT_W'(FIFO_DEPTH)) && !ap_rst;
  assign pop    = fifo_valid && bus.rsp_ready;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    op_d    = '0;
    op_d.id = MUL_ID_W'(win_idx);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        op_d.a = bus.req_a[i*MUL_IN_W +: MUL_IN_W];
        op_d.b = bus.req_b[i*MUL_IN_W +: MUL_IN_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_q   <= '0;
      credits_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      s1_op_q <= op_d;
    end
  end

  // Stage 1 holds operands; remaining stages hold the product so synthesis can
  // fold them into the DSP's internal pipeline registers.
  generate
    if (MUL_STAGES == 1) begin : g_one_stage
      assign fifo_wr      = s1_valid_q;
      assign fifo_wr_data = '{p: mul_full(s1_op_q.a, s1_op_q.b), id: s1_op_q.id};
    end else begin : g_multi_stage
      logic     pv_q [MUL_STAGES-1];
      mul_rsp_t pd_q [MUL_STAGES-1];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int k = 0; k < MUL_STAGES - 1; k++) begin
            pv_q[k] <= 1'b0;
          end
        end else begin
          pv_q[0] <= s1_valid_q;
          for (int k = 1; k < MUL_STAGES - 1; k++) begin
            pv_q[k] <= pv_q[k-1];
          end
        end
      end

      always_ff @(posedge ap_clk) begin
        pd_q[0] <= '{p: mul_full(s1_op_q.a, s1_op_q.b), id: s1_op_q.id};
        for (int k = 1; k < MUL_STAGES - 1; k++) begin
          pd_q[k] <= pd_q[k-1];
        end
      end

      assign fifo_wr      = pv_q[MUL_STAGES-2];
      assign fifo_wr_data = pd_q[MUL_STAGES-2];
    end
  endgenerate

  lrhls_mul_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (ap_clk),
    .rst_i      (ap_rst),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (fifo_wr_data),
    .rd_en_i    (bus.rsp_ready),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (fifo_head),
    .count_o    (fifo_count)
  );

  // Credits count queued entries too, so they can never fall below occupancy.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      assert (fifo_count <= credits_q);
    end
  end

  // Tag bits above ID_W are always zero for smaller requester counts.
  logic unused_id_hi;
  assign unused_id_hi = ^fifo_head.id;

  assign bus.rsp_valid    = fifo_valid;
  assign bus.rsp_data     = fifo_head.p;
  assign bus.rsp_id       = fifo_head.id[ID_W-1:0];
  assign bus.credits_used = credits_q;

endmodule
